// File: rtl/ycbcr2rgb_stream_ctrl.sv
// rtl/ycbcr2rgb_stream_ctrl.sv - credit-based flow control around a fixed-latency YCbCr-to-RGB converter
// Tags ride a shift register matched to the converter latency; results land in a FWFT output FIFO.
module ycbcr2rgb_stream_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int CONV_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ctrl_enable,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [3*DATA_WIDTH-1:0] s_ycbcr,
    input  logic                    s_sof,
    input  logic                    s_eol,
    output logic                    conv_en,
    output logic [DATA_WIDTH-1:0]   conv_y,
    output logic [DATA_WIDTH-1:0]   conv_cb,
    output logic [DATA_WIDTH-1:0]   conv_cr,
    input  logic [DATA_WIDTH-1:0]   conv_r,
    input  logic [DATA_WIDTH-1:0]   conv_g,
    input  logic [DATA_WIDTH-1:0]   conv_b,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [3*DATA_WIDTH-1:0] m_rgb,
    output logic                    m_sof,
    output logic                    m_eol,
    output logic                    busy,
    output logic [15:0]             sync_drop_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 3 * DATA_WIDTH + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_ACTIVE, ST_DRAIN} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CONV_LATENCY-1:0] r_tag_vld;
    logic [CONV_LATENCY-1:0] r_tag_sof;
    logic [CONV_LATENCY-1:0] r_tag_eol;
    logic [EW-1:0]           r_mem [FIFO_DEPTH];
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic [15:0]             r_drop_cnt;

    logic [CW-1:0] w_inflight;
    logic [CW:0]   w_occupancy;
    logic          w_credit_ok;
    logic          w_issue;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic [EW-1:0] w_head;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < CONV_LATENCY; i++) begin
            w_inflight = w_inflight + CW'(r_tag_vld[i]);
        end
    end

    // Occupancy counts pixels already committed to a FIFO slot, so a pop this cycle never grants credit early.
    assign w_occupancy = {1'b0, r_count} + {1'b0, w_inflight};
    assign w_credit_ok = (w_occupancy < DEPTH_W);

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        w_issue     = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ctrl_enable) w_state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                s_ready = !(s_sof && !w_credit_ok);
                if (s_valid && s_ready) begin
                    if (s_sof) begin
                        w_issue     = 1'b1;
                        w_state_nxt = ST_ACTIVE;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
                if (!ctrl_enable && !w_issue) w_state_nxt = ST_IDLE;
            end
            ST_ACTIVE: begin
                s_ready = w_credit_ok;
                if (s_valid && w_credit_ok) begin
                    w_issue = 1'b1;
                    if (!ctrl_enable && s_eol) w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_inflight == '0 && r_count == '0) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign conv_en = w_issue;
    assign conv_y  = w_issue ? s_ycbcr[3*DATA_WIDTH-1:2*DATA_WIDTH] : '0;
    assign conv_cb = w_issue ? s_ycbcr[2*DATA_WIDTH-1:DATA_WIDTH]   : '0;
    assign conv_cr = w_issue ? s_ycbcr[DATA_WIDTH-1:0]              : '0;

    assign w_push  = r_tag_vld[CONV_LATENCY-1];
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);
    assign w_pop   = !w_empty && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_tag_vld  <= '0;
            r_tag_sof  <= '0;
            r_tag_eol  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_tag_vld[0] <= w_issue;
            r_tag_sof[0] <= w_issue && s_sof;
            r_tag_eol[0] <= w_issue && s_eol;
            for (int i = 1; i < CONV_LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_sof[i] <= r_tag_sof[i-1];
                r_tag_eol[i] <= r_tag_eol[i-1];
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {conv_r, conv_g, conv_b,
                                r_tag_sof[CONV_LATENCY-1], r_tag_eol[CONV_LATENCY-1]};
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_full));

    // Gate the head so stale RAM contents never appear on the outputs while empty.
    assign w_head              = w_empty ? '0 : r_mem[r_rd_ptr];
    assign {m_rgb, m_sof, m_eol} = w_head;
    assign m_valid             = !w_empty;
    assign busy                = (r_state != ST_IDLE);
    assign sync_drop_cnt       = r_drop_cnt;
endmodule
